out_buf_drain: RTL and testbench

- Reads accumulated results out of the compute cluster output buffers.
- Walks the (compute unit, accumulation buffer) select space, captures each OUTPUT_BUF_W-bit word and serialises it onto a BUS_W-bit valid/ready stream towards the writeback path.
- Read-side counterpart of the chunk-write loader: the loader fills chunk memories, this block empties the output buffers after total_chunk_end.

---
 rtl/out_buf_drain_if.sv | 34 +++
 rtl/out_buf_drain.sv | 159 +++++++++++++++
 tb/tb_out_buf_drain.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/out_buf_drain_if.sv
// Stream and select bundle between the output-buffer drain and its surroundings.
// The drain side uses the master modport; the cluster/writeback side uses slave.
interface out_buf_drain_if #(
    parameter int COMPUTE_UNIT_NUM = 4,
    parameter int OUTPUT_BUF_NUM   = 4,
    parameter int OUTPUT_BUF_W     = 128,
    parameter int BUS_W            = 32
);
    logic                                start_i;
    logic [$clog2(OUTPUT_BUF_NUM):0]     buf_num_i;
    logic [COMPUTE_UNIT_NUM-1:0]         cu_mask_i;
    logic                                busy_o;
    logic                                done_o;
    logic [$clog2(COMPUTE_UNIT_NUM)-1:0] com_unit_out_buf_sel_o;
    logic [$clog2(OUTPUT_BUF_NUM)-1:0]   acc_buf_sel_o;
    logic [OUTPUT_BUF_W-1:0]             out_buf_dat_i;
    logic [BUS_W-1:0]                    dat_o;
    logic                                valid_o;
    logic                                ready_i;
    logic                                last_o;
    logic [31:0]                         beat_cnt_o;

    modport master (
        input  start_i, buf_num_i, cu_mask_i, out_buf_dat_i, ready_i,
        output busy_o, done_o, com_unit_out_buf_sel_o, acc_buf_sel_o,
               dat_o, valid_o, last_o, beat_cnt_o
    );

    modport slave (
        output start_i, buf_num_i, cu_mask_i, out_buf_dat_i, ready_i,
        input  busy_o, done_o, com_unit_out_buf_sel_o, acc_buf_sel_o,
               dat_o, valid_o, last_o, beat_cnt_o
    );
endinterface

// File: rtl/out_buf_drain.sv
// Output-buffer drain: walks enabled (compute unit, accumulation buffer) pairs,
// captures each buffer word after the read latency and serialises it LSB slice
// first onto a valid/ready stream, flagging the final beat of the whole drain.
module out_buf_drain #(
    parameter int COMPUTE_UNIT_NUM = 4,
    parameter int OUTPUT_BUF_NUM   = 4,
    parameter int OUTPUT_BUF_W     = 128,
    parameter int BUS_W            = 32,
    parameter int RD_LAT           = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    out_buf_drain_if.master bus
);
    localparam int CU_W   = $clog2(COMPUTE_UNIT_NUM);
    localparam int BI_W   = $clog2(OUTPUT_BUF_NUM);
    localparam int BN_W   = BI_W + 1;
    localparam int BEATS  = OUTPUT_BUF_W / BUS_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAIT_W = $clog2(RD_LAT + 1);

    localparam logic [BN_W-1:0]   BN_ONE    = BN_W'(1);
    localparam logic [BN_W-1:0]   BUF_MAX   = BN_W'(OUTPUT_BUF_NUM);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RD_LAT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [2:0] {IDLE, SEL, WAIT, CAP, SEND, DONE} state_t;

    state_t                  state;
    logic [COMPUTE_UNIT_NUM-1:0] mask_q;
    logic [BN_W-1:0]         buf_num_q;
    logic [CU_W-1:0]         cu_idx;
    logic [BI_W-1:0]         buf_idx;
    logic [BEAT_W-1:0]       beat;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [OUTPUT_BUF_W-1:0] shift_reg;
    logic [CU_W-1:0]         first_cu;
    logic [CU_W-1:0]         nxt_cu;
    logic                    nxt_cu_found;
    logic                    is_final;
    logic                    xfer;

    // Buffer counts beyond the physical buffer count saturate to it.
    function automatic logic [BN_W-1:0] sat_buf_num(input logic [BN_W-1:0] n);
        return (n > BUF_MAX) ? BUF_MAX : n;
    endfunction

    // Lowest set bit of the incoming mask, and next enabled CU above cu_idx.
    always_comb begin
        first_cu     = '0;
        nxt_cu       = '0;
        nxt_cu_found = 1'b0;
        for (int i = COMPUTE_UNIT_NUM - 1; i >= 0; i--) begin
            if (bus.cu_mask_i[i]) first_cu = CU_W'(i);
            if (mask_q[i] && (i > int'(cu_idx))) begin
                nxt_cu_found = 1'b1;
                nxt_cu       = CU_W'(i);
            end
        end
    end

    assign is_final  = ({1'b0, buf_idx} == (buf_num_q - BN_ONE)) && !nxt_cu_found;
    assign xfer      = bus.valid_o && bus.ready_i;
    assign bus.dat_o = bus.valid_o ? shift_reg[BUS_W-1:0] : '0;

    // Control FSM: select walk, read-latency wait, capture and beat sequencing.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state                      <= IDLE;
            bus.busy_o                 <= 1'b0;
            bus.done_o                 <= 1'b0;
            bus.com_unit_out_buf_sel_o <= '0;
            bus.acc_buf_sel_o          <= '0;
            bus.valid_o                <= 1'b0;
            bus.last_o                 <= 1'b0;
            bus.beat_cnt_o             <= '0;
            mask_q                     <= '0;
            buf_num_q                  <= '0;
            cu_idx                     <= '0;
            buf_idx                    <= '0;
            beat                       <= '0;
            wait_cnt                   <= '0;
        end else begin
            bus.done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        mask_q         <= bus.cu_mask_i;
                        buf_num_q      <= sat_buf_num(bus.buf_num_i);
                        bus.beat_cnt_o <= '0;
                        bus.busy_o     <= 1'b1;
                        if (bus.cu_mask_i == '0 || bus.buf_num_i == '0) begin
                            state <= DONE;
                        end else begin
                            cu_idx  <= first_cu;
                            buf_idx <= '0;
                            state   <= SEL;
                        end
                    end
                end
                SEL: begin
                    bus.com_unit_out_buf_sel_o <= cu_idx;
                    bus.acc_buf_sel_o          <= buf_idx;
                    wait_cnt                   <= WAIT_INIT;
                    state                      <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - WAIT_ONE;
                    if (wait_cnt == WAIT_ONE) state <= CAP;
                end
                CAP: begin
                    beat        <= '0;
                    bus.valid_o <= 1'b1;
                    bus.last_o  <= (BEATS == 1) && is_final;
                    state       <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        bus.beat_cnt_o <= bus.beat_cnt_o + 32'd1;
                        if (beat == LAST_BEAT) begin
                            bus.valid_o <= 1'b0;
                            bus.last_o  <= 1'b0;
                            if ({1'b0, buf_idx} != (buf_num_q - BN_ONE)) begin
                                buf_idx <= buf_idx + BI_W'(1);
                                state   <= SEL;
                            end else if (nxt_cu_found) begin
                                buf_idx <= '0;
                                cu_idx  <= nxt_cu;
                                state   <= SEL;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            beat       <= beat + BEAT_ONE;
                            bus.last_o <= ((beat + BEAT_ONE) == LAST_BEAT) && is_final;
                        end
                    end
                end
                DONE: begin
                    bus.done_o <= 1'b1;
                    bus.busy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word shift register: loaded on capture, shifted one slice per transfer.
    always_ff @(posedge clk_i) begin
        if (state == CAP) begin
            shift_reg <= bus.out_buf_dat_i;
        end else if (state == SEND && xfer) begin
            shift_reg <= shift_reg >> BUS_W;
        end
    end
endmodule

// File: tb/tb_out_buf_drain.sv
// Bench for out_buf_drain: cluster read model with RD_LAT delay, scoreboard of
// expected beats, table of drain scenarios plus reset and busy-start sequences.
module tb_out_buf_drain;
    localparam int RD_LAT = 1;
    localparam logic [127:0] FIXED = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    out_buf_drain_if bus();
    out_buf_drain #(.RD_LAT(RD_LAT)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    typedef struct { logic [31:0] dat; logic last; } beat_t;
    typedef struct {
        logic [3:0] mask; logic [2:0] buf_num;
        bit fixed; bit rnd; bit stall;
        int exp_beats; int exp_done_cyc;
    } vec_t;

    beat_t sb_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    bit    fixed_mode = 1'b0;
    bit    done_seen = 1'b0;
    bit    valid_seen = 1'b0;
    logic [3:0] sel_d [RD_LAT];

    function automatic logic [127:0] enc_word(input logic [1:0] cu, input logic [1:0] b);
        logic [127:0] w;
        for (int k = 0; k < 16; k++) w[8*k +: 8] = {4'(k), cu, b};
        return w;
    endfunction

    // Cluster model: data follows the selects after RD_LAT clocks.
    always @(posedge clk_i) begin
        sel_d[0] <= {bus.com_unit_out_buf_sel_o, bus.acc_buf_sel_o};
        for (int i = 1; i < RD_LAT; i++) sel_d[i] <= sel_d[i-1];
    end
    assign bus.out_buf_dat_i = fixed_mode ? FIXED
                             : enc_word(sel_d[RD_LAT-1][3:2], sel_d[RD_LAT-1][1:0]);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic int clamp(input logic [2:0] n);
        return (n > 3'd4) ? 4 : int'(n);
    endfunction

    task automatic push_exp(input logic [3:0] mask, input logic [2:0] buf_num, input bit fixed);
        int nb = clamp(buf_num);
        int top = -1;
        beat_t e;
        for (int c = 0; c < 4; c++) if (mask[c]) top = c;
        for (int c = 0; c < 4; c++) begin
            if (!mask[c]) continue;
            for (int b = 0; b < nb; b++) begin
                for (int bt = 0; bt < 4; bt++) begin
                    if (fixed) e.dat = 32'h1111_1111 * (bt + 1);
                    else for (int j = 0; j < 4; j++) e.dat[8*j +: 8] = {4'(4*bt + j), 2'(c), 2'(b)};
                    e.last = (c == top) && (b == nb - 1) && (bt == 3);
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    // Stream monitor: scoreboard pops on transfer, stall stability checks.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat;
    logic        prev_last;
    beat_t       got_b;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (!(bus.valid_o && bus.dat_o == prev_dat && bus.last_o == prev_last)) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%b dat=%h last=%b required valid=1 dat=%h last=%b",
                             bus.valid_o, bus.dat_o, bus.last_o, prev_dat, prev_last);
                end
            end
            if (bus.valid_o && bus.ready_i) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got dat=%h required no beat", bus.dat_o);
                end else begin
                    got_b = sb_q.pop_front();
                    if (bus.dat_o !== got_b.dat || bus.last_o !== got_b.last) begin
                        n_fail++;
                        $display("FAIL beat: got dat=%h last=%b required dat=%h last=%b",
                                 bus.dat_o, bus.last_o, got_b.dat, got_b.last);
                    end
                end
            end
            prev_stall = bus.valid_o && !bus.ready_i;
            prev_dat   = bus.dat_o;
            prev_last  = bus.last_o;
            if (bus.done_o)  done_seen  = 1'b1;
            if (bus.valid_o) valid_seen = 1'b1;
        end
    end

    task automatic start_drain(input logic [3:0] mask, input logic [2:0] buf_num, input bit fixed);
        fixed_mode = fixed;
        push_exp(mask, buf_num, fixed);
        valid_seen = 1'b0;
        bus.cu_mask_i = mask;
        bus.buf_num_i = buf_num;
        bus.start_i   = 1'b1;
        @(posedge clk_i); #1;
        bus.start_i   = 1'b0;
        chk("busy_after_start", bus.busy_o, 1);
    endtask

    task automatic wait_done(input bit rnd, input bit stall, output int cyc, output bit got);
        int stall_left = 0;
        bit stalled = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 4000) begin
            if (stall_left > 0) begin
                bus.ready_i = 1'b0;
                stall_left--;
            end else if (stall && !stalled && bus.valid_o && bus.beat_cnt_o == 32'd6) begin
                bus.ready_i = 1'b0;
                stall_left = 9;
                stalled = 1'b1;
            end else begin
                bus.ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(posedge clk_i); #1;
            cyc++;
            if (bus.done_o) got = 1'b1;
        end
        bus.ready_i = 1'b1;
        chk("done_reached", got, 1);
    endtask

    task automatic run_drain(input vec_t v);
        int cyc;
        bit got;
        start_drain(v.mask, v.buf_num, v.fixed);
        wait_done(v.rnd, v.stall, cyc, got);
        if (v.exp_done_cyc >= 0) chk("done_latency", cyc, v.exp_done_cyc);
        chk("beat_cnt", bus.beat_cnt_o, v.exp_beats);
        chk("sb_empty", sb_q.size(), 0);
        chk("busy_at_done", bus.busy_o, 0);
        if (v.exp_beats == 0) chk("no_valid", valid_seen, 0);
        @(posedge clk_i); #1;
        chk("done_pulse_len", bus.done_o, 0);
        sb_q.delete();
    endtask

    initial begin
        vec_t vecs[7];
        int   cyc;
        bit   got;
        bus.start_i = 1'b0; bus.buf_num_i = '0; bus.cu_mask_i = '0; bus.ready_i = 1'b1;
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_last", bus.last_o, 0);
        chk("rst_dat", bus.dat_o, 0);
        chk("rst_cnt", bus.beat_cnt_o, 0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        //          mask     bn    fix rnd stl beats done_cyc
        vecs[0] = '{4'b0001, 3'd1, 1, 0, 0, 4,  8};
        vecs[1] = '{4'b1111, 3'd4, 0, 0, 0, 64, 113};
        vecs[2] = '{4'b1010, 3'd2, 0, 0, 0, 16, 29};
        vecs[3] = '{4'b1111, 3'd4, 0, 1, 1, 64, -1};
        vecs[4] = '{4'b0101, 3'd0, 0, 0, 0, 0,  1};
        vecs[5] = '{4'b0000, 3'd3, 0, 0, 0, 0,  1};
        vecs[6] = '{4'b0001, 3'd7, 0, 0, 0, 16, 29};
        for (int i = 0; i < 7; i++) run_drain(vecs[i]);

        // Start while busy must be ignored.
        start_drain(4'b0001, 3'd1, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        bus.cu_mask_i = 4'b1111; bus.buf_num_i = 3'd4; bus.start_i = 1'b1;
        @(posedge clk_i); #1;
        bus.start_i = 1'b0;
        wait_done(1'b0, 1'b0, cyc, got);
        chk("busy_start_cnt", bus.beat_cnt_o, 4);
        chk("busy_start_sb", sb_q.size(), 0);
        sb_q.delete();
        @(posedge clk_i); #1;

        // Asynchronous reset during the second buffer of a drain.
        start_drain(4'b0001, 3'd2, 1'b0);
        cyc = 0;
        while (bus.beat_cnt_o != 32'd5 && cyc < 200) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        chk("reach_2nd_buf", bus.beat_cnt_o, 5);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_busy", bus.busy_o, 0);
        chk("arst_done", bus.done_o, 0);
        chk("arst_valid", bus.valid_o, 0);
        chk("arst_last", bus.last_o, 0);
        chk("arst_dat", bus.dat_o, 0);
        chk("arst_cu_sel", bus.com_unit_out_buf_sel_o, 0);
        chk("arst_acc_sel", bus.acc_buf_sel_o, 0);
        chk("arst_cnt", bus.beat_cnt_o, 0);
        sb_q.delete();
        done_seen = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        chk("no_done_after_rst", done_seen, 0);
        chk("idle_after_rst", bus.busy_o, 0);

        // Fresh start after reset completes normally.
        run_drain(vecs[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
